// File: rtl/vga_capture_if.sv
// vga_capture_if: groups the VGA input bus, the ARM request and the
// down-sampled frame-buffer write port of vga_capture.
// master = video source / buffer side, slave = the capture block.
interface vga_capture_if;
    logic       VGA_HSYNC;
    logic       VGA_VSYNC;
    logic       VGA_BLANK;
    logic [9:0] VGA_R;
    logic [9:0] VGA_G;
    logic [9:0] VGA_B;
    logic       ARM;
    logic [7:0] X;
    logic [7:0] Y;
    logic [11:0] RGB;
    logic       WR;
    logic       BUSY;
    logic       FRAME_DONE;

    modport master (
        output VGA_HSYNC, VGA_VSYNC, VGA_BLANK, VGA_R, VGA_G, VGA_B, ARM,
        input  X, Y, RGB, WR, BUSY, FRAME_DONE
    );

    modport slave (
        input  VGA_HSYNC, VGA_VSYNC, VGA_BLANK, VGA_R, VGA_G, VGA_B, ARM,
        output X, Y, RGB, WR, BUSY, FRAME_DONE
    );
endinterface

// File: rtl/vga_capture.sv
// vga_capture: captures one VGA frame into a 4x down-sampled buffer
// (every 4th pixel of every 4th line, 4-bit colour per channel).
// Optional macro VGA_CAPTURE_AVG_EN: instead of taking column%4==0,
// average the 4 pixels of each horizontal group; incomplete groups
// (line ends early) are discarded.
module vga_capture #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic          CLOCK_25,
    input  logic          RESET_N,
    vga_capture_if.slave  vga
);

    localparam logic [9:0] C_H_ACT = 10'(H_ACT);
    localparam logic [8:0] C_V_ACT = 9'(V_ACT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blank;
    logic [9:0]  r_col;
    logic [8:0]  r_row;
    logic        r_wr;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [11:0] r_rgb;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_blank_fall;
    logic        w_eligible;
    logic [3:0]  w_nib_r;
    logic [3:0]  w_nib_g;
    logic [3:0]  w_nib_b;
    logic        w_unused;

    // Edges compare the previous-cycle registered copy with the live input.
    assign w_hs_fall    = r_hsync & ~vga.VGA_HSYNC;
    assign w_vs_fall    = r_vsync & ~vga.VGA_VSYNC;
    assign w_blank_fall = r_blank & ~vga.VGA_BLANK;

    assign w_nib_r = vga.VGA_R[9:6];
    assign w_nib_g = vga.VGA_G[9:6];
    assign w_nib_b = vga.VGA_B[9:6];
    assign w_unused = ^{vga.VGA_R[5:0], vga.VGA_G[5:0], vga.VGA_B[5:0]};

    // Only every 4th line inside the active window contributes to the buffer.
    assign w_eligible = (r_state == S_CAPTURE) && vga.VGA_BLANK &&
                        (r_col < C_H_ACT) && (r_row < C_V_ACT) &&
                        (r_row[1:0] == 2'b00);

    // Sync/blank registers and the saturating column counter.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b0;
            r_col   <= '0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // update together from the pre-edge values, whatever the order.
            r_hsync <= vga.VGA_HSYNC;
            r_vsync <= vga.VGA_VSYNC;
            r_blank <= vga.VGA_BLANK;
            if (w_hs_fall) begin
                r_col <= '0;
            end else if (vga.VGA_BLANK && (r_col < C_H_ACT)) begin
                r_col <= r_col + 10'd1;
            end
        end
    end

    // Capture FSM with registered BUSY/FRAME_DONE and the row counter.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_row   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (vga.ARM) begin
                        r_state <= S_ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (w_vs_fall) begin
                        r_state <= S_CAPTURE;
                        r_row   <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_vs_fall) begin
                        r_done  <= 1'b1;
                        r_state <= vga.ARM ? S_ARMED : S_IDLE;
                        r_busy  <= vga.ARM;
                    end else if (w_blank_fall && (r_row < C_V_ACT)) begin
                        r_row <= r_row + 9'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VGA_CAPTURE_AVG_EN
    logic [5:0] r_acc_r;
    logic [5:0] r_acc_g;
    logic [5:0] r_acc_b;
    logic [5:0] w_sum_r;
    logic [5:0] w_sum_g;
    logic [5:0] w_sum_b;

    assign w_sum_r = r_acc_r + 6'(w_nib_r);
    assign w_sum_g = r_acc_g + 6'(w_nib_g);
    assign w_sum_b = r_acc_b + 6'(w_nib_b);

    // Accumulate 4 horizontal pixels; write their truncated mean on the 4th.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_acc_r <= '0;
            r_acc_g <= '0;
            r_acc_b <= '0;
            r_wr    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_rgb   <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_eligible) begin
                if (r_col[1:0] == 2'd0) begin
                    r_acc_r <= 6'(w_nib_r);
                    r_acc_g <= 6'(w_nib_g);
                    r_acc_b <= 6'(w_nib_b);
                end else if (r_col[1:0] == 2'd3) begin
                    r_acc_r <= '0;
                    r_acc_g <= '0;
                    r_acc_b <= '0;
                    r_wr    <= 1'b1;
                    r_x     <= r_col[9:2];
                    r_y     <= {1'b0, r_row[8:2]};
                    r_rgb   <= {w_sum_b[5:2], w_sum_g[5:2], w_sum_r[5:2]};
                end else begin
                    r_acc_r <= w_sum_r;
                    r_acc_g <= w_sum_g;
                    r_acc_b <= w_sum_b;
                end
            end else if (w_blank_fall) begin
                r_acc_r <= '0;
                r_acc_g <= '0;
                r_acc_b <= '0;
            end
        end
    end
`else
    // Point-sample column%4==0; the write appears one cycle after the pixel.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr  <= 1'b0;
            r_x   <= '0;
            r_y   <= '0;
            r_rgb <= '0;
        end else begin
            r_wr <= 1'b0;
            if (w_eligible && (r_col[1:0] == 2'd0)) begin
                r_wr  <= 1'b1;
                r_x   <= r_col[9:2];
                r_y   <= {1'b0, r_row[8:2]};
                r_rgb <= {w_nib_b, w_nib_g, w_nib_r};
            end
        end
    end
`endif

    assign vga.X          = r_x;
    assign vga.Y          = r_y;
    assign vga.RGB        = r_rgb;
    assign vga.WR         = r_wr;
    assign vga.BUSY       = r_busy;
    assign vga.FRAME_DONE = r_done;

endmodule
